tx_add_cyclic_prefix: RTL
=========================

Name: tx_add_cyclic_prefix

Overview:
- Inserts the 802.11a cyclic prefix on DATA-field OFDM symbols.
- Accepts 64-sample time-domain IFFT symbols and emits each as 80 samples: the last 16 samples (CP), then all 64.
- Drives the DATA-field input of the TX output arranger.
- Ping-pong buffered, so a new symbol can load while the previous one streams out.

Parameters:
- SYM_LEN, 64, samples per IFFT symbol (power of two).
- CP_LEN, 16, cyclic prefix length (< SYM_LEN).
- DW, 16, width of each I/Q component.

Ports:
- clk_Modulation  in  1  modulation clock.
- reset  in  1  synchronous, active-high.
- ifft_valid  in  1  input sample valid.
- ifft_re  in  DW  input real component.
- ifft_im  in  DW  input imaginary component.
- ifft_last  in  1  current symbol is the final DATA symbol; sampled with sample index SYM_LEN-1.
- ifft_ready  out  1  block can accept a sample this cycle.
- tx_add_cyclic_prefix_valid  out  1  output sample valid.
- tx_add_cyclic_prefix_re  out  DW  output real component.
- tx_add_cyclic_prefix_im  out  DW  output imaginary component.
- tx_add_cyclic_prefix_end  out  1  single-cycle pulse on the last output sample of the last symbol.

Behaviour:
- Reset is synchronous, active-high; clock is clk_Modulation.
- Reset values: ifft_ready=1, all outputs 0, both bank-full flags 0, write bank 0, write index 0, read FSM in IDLE.
- Storage: two banks of SYM_LEN x 2*DW, stored as {im,re}; read is registered with 1-cycle latency.
- Write side:
  - A sample is accepted when ifft_valid & ifft_ready.
  - An accepted sample is written to write bank, address wr_idx; wr_idx increments.
  - On the accept with wr_idx=SYM_LEN-1: set full[wr_bank], store last[wr_bank]=ifft_last, toggle wr_bank, clear wr_idx.
  - ifft_ready = ~full[wr_bank].
  - Gaps in ifft_valid are allowed and do not affect stored data.
- Read FSM states: IDLE, CP, BODY.
  - IDLE -> CP when full[rd_bank]=1; issue address SYM_LEN-CP_LEN that cycle.
  - CP issues addresses SYM_LEN-CP_LEN .. SYM_LEN-1, one per cycle, then -> BODY.
  - BODY issues addresses 0 .. SYM_LEN-1, one per cycle.
  - On issuing address SYM_LEN-1 in BODY: clear full[rd_bank] (effective next cycle) and toggle rd_bank.
  - After that issue, go to CP if full[other bank] is already set (back-to-back, zero gap); otherwise go to IDLE.
- Output:
  - tx_add_cyclic_prefix_valid is the issue strobe delayed 1 cycle, aligned with RAM data.
  - Exactly SYM_LEN+CP_LEN consecutive valid cycles per symbol; no downstream backpressure.
  - re/im hold the last value when valid=0.
- End pulse: tx_add_cyclic_prefix_end = 1 together with the final valid sample (BODY address SYM_LEN-1) of a bank whose last flag is set. The pulse is then cleared.
- Latency: 64th sample accepted at cycle t, read bank idle -> first output valid at t+2.
- Simultaneous events:
  - A write-side set of full[] and a read-side clear of full[] in the same cycle always target different banks; both take effect.
  - When both banks are full, ifft_ready=0 until the read side clears a bank. ready rises the cycle after the last BODY issue.
- Reset mid-operation: in-flight symbols are discarded. Output valid and end are low the cycle after reset asserts; no partial symbol is emitted after reset deasserts.
- Widths: no arithmetic on data; the address counter is log2(SYM_LEN) bits and wraps naturally at SYM_LEN-1 -> 0.

Test Plan:
- Single symbol, re=n, im=-n for n=0..63, ifft_last=1, contiguous:
  - 80 valid cycles starting 2 cycles after sample 63.
  - re sequence 48..63 then 0..63.
  - end high only on the 80th cycle (re=63).
- Two contiguous symbols, first re=0..63, second re=100..163, last on the second only:
  - 160 consecutive valid cycles with no gap.
  - second CP starts at re=148.
  - end only on re=163.
- Three symbols fed with ifft_valid held high:
  - ifft_ready drops after the 128th accept and re-rises once the first symbol's BODY address 63 is issued.
  - all 192 input samples appear in order; 240 output samples total.
- Gapped input (valid on alternate cycles), one symbol: output identical to the first test; first output 2 cycles after the 64th accept.
- Reset asserted at output sample 30 of symbol 1 with symbol 2 buffered:
  - valid=0 and ready=1 next cycle.
  - no output until a fresh 64 samples are written; the fresh symbol is emitted correctly.
- Symbol with ifft_last=0 followed by IDLE: 80 valid outputs, end never asserted, FSM returns to IDLE.

Source files
------------

// File: rtl/tx_add_cyclic_prefix.sv
// Cyclic-prefix inserter for 802.11a DATA-field OFDM symbols.
// Each SYM_LEN-sample IFFT symbol is replayed as its last CP_LEN samples followed by all SYM_LEN samples.
module tx_add_cyclic_prefix #(
    parameter int SYM_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int DW      = 16
) (
    input  logic          clk_Modulation,
    input  logic          reset,
    input  logic          ifft_valid,
    input  logic [DW-1:0] ifft_re,
    input  logic [DW-1:0] ifft_im,
    input  logic          ifft_last,
    output logic          ifft_ready,
    output logic          tx_add_cyclic_prefix_valid,
    output logic [DW-1:0] tx_add_cyclic_prefix_re,
    output logic [DW-1:0] tx_add_cyclic_prefix_im,
    output logic          tx_add_cyclic_prefix_end
);
    localparam int            AW       = $clog2(SYM_LEN);
    localparam logic [AW-1:0] CP_START = AW'(SYM_LEN - CP_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(SYM_LEN - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CP,
        RD_BODY
    } rd_state_e;

    logic [2*DW-1:0] bank0_mem [SYM_LEN];
    logic [2*DW-1:0] bank1_mem [SYM_LEN];

    logic [1:0]      full_q, full_d;
    logic [1:0]      last_q, last_d;
    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d;
    rd_state_e       state_q, state_d;
    logic            valid_q, valid_d;
    logic            end_q, end_d;
    logic [2*DW-1:0] data_q, data_d;

    logic            wr_accept;
    logic            rd_issue;
    logic            rd_clear;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_word;

    assign ifft_ready = ~full_q[wr_bank_q];
    assign wr_accept  = ifft_valid & ifft_ready;

    // NOTE: sample storage is deliberately not reset; the full flags alone decide what is valid.
    always_ff @(posedge clk_Modulation) begin
        if (wr_accept) begin
            if (wr_bank_q) bank1_mem[wr_idx_q] <= {ifft_im, ifft_re};
            else           bank0_mem[wr_idx_q] <= {ifft_im, ifft_re};
        end
    end

    assign rd_word = rd_bank_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

    // Read sequencer: CP tail first, then the whole body; chains straight into the other bank if it is ready.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        rd_issue  = 1'b0;
        rd_addr   = rd_idx_q;
        rd_clear  = 1'b0;
        end_d     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_issue = 1'b1;
                    rd_addr  = CP_START;
                    rd_idx_d = CP_START + 1'b1;
                    state_d  = (CP_START == LAST_IDX) ? RD_BODY : RD_CP;
                end
            end
            RD_CP: begin
                rd_issue = 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_idx_q == LAST_IDX) state_d = RD_BODY;
            end
            RD_BODY: begin
                rd_issue = 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_idx_q == LAST_IDX) begin
                    rd_clear  = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    end_d     = last_q[rd_bank_q];
                    if (full_q[~rd_bank_q]) begin
                        state_d  = RD_CP;
                        rd_idx_d = CP_START;
                    end else begin
                        state_d  = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Write side; a read-side clear and a write-side set always hit different banks.
    always_comb begin
        full_d    = full_q;
        last_d    = last_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        if (rd_clear) full_d[rd_bank_q] = 1'b0;
        if (wr_accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                last_d[wr_bank_q] = ifft_last;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_comb begin
        valid_d = rd_issue;
        data_d  = rd_issue ? rd_word : data_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_Modulation) begin
        if (reset) begin
            full_q    <= '0;
            last_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            state_q   <= RD_IDLE;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            full_q    <= full_d;
            last_q    <= last_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            data_q    <= data_d;
        end
    end

    assign tx_add_cyclic_prefix_valid = valid_q;
    assign tx_add_cyclic_prefix_re    = data_q[DW-1:0];
    assign tx_add_cyclic_prefix_im    = data_q[2*DW-1:DW];
    assign tx_add_cyclic_prefix_end   = end_q;

endmodule
